// File: rtl/riscv_pkg.sv
// Shared RV32 constants and types for the fetch stage.
// Holds the bubble encoding, the fetch FSM states and the IF/ID register layout.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem address/data, hazard controls, Execute redirect and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the StallCnt/FlushCnt counter outputs.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            stall;
    logic            flush;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic [XLEN-1:0] InstrF;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            MisalignF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     StallCnt;
    logic [31:0]     FlushCnt;
`endif

`ifdef FETCH_PERF_CNT_EN
    modport master (
        input  stall, flush, PCSrcE, PCTargetE, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignF, StallCnt, FlushCnt
    );
    modport slave (
        output stall, flush, PCSrcE, PCTargetE, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignF, StallCnt, FlushCnt
    );
`else
    modport master (
        input  stall, flush, PCSrcE, PCTargetE, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignF
    );
    modport slave (
        output stall, flush, PCSrcE, PCTargetE, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, MisalignF
    );
`endif

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with its next-PC mux: redirect, then stall hold, then PC+4.
// The PC is frozen at RESET_PC until the fetch FSM reaches RUN.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;

    // Wraps modulo 2^32 at the top of the address space.
    assign pc_plus4 = pc_q + XLEN'(4);
    assign pc       = pc_q;

    // NOTE: a combinational block assigns every output a default first, so no path infers a latch.
    always_comb begin
        pc_next = pc_q;
        if (run) begin
            if (redirect)    pc_next = target;
            else if (!stall) pc_next = pc_plus4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_next;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage: boot FSM, PC register (pc_reg) and the IF/ID pipeline register.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush event counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e    state_q;
    fetch_state_e    state_next;
    ifid_t           ifid_q;
    ifid_t           ifid_next;
    logic            run;
    logic [XLEN-1:0] pc_plus4f;
    logic            misalign_q;

    always_comb begin
        state_next = state_q;
        unique case (state_q)
            BOOT:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BOOT;
        else        state_q <= state_next;
    end

    assign run = (state_q == RUN);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .stall    (bus.stall),
        .redirect (bus.PCSrcE),
        .target   (bus.PCTargetE),
        .pc       (bus.PCF),
        .pc_plus4 (pc_plus4f)
    );

    // A bubble keeps PCD/PCPlus4D; only the instruction and valid bit are replaced.
    always_comb begin
        ifid_next = ifid_q;
        if (!run || bus.flush || bus.PCSrcE) begin
            ifid_next.instr = NOP_INSTR;
            ifid_next.valid = 1'b0;
        end else if (!bus.stall) begin
            ifid_next.instr    = bus.InstrF;
            ifid_next.pc       = bus.PCF;
            ifid_next.pc_plus4 = pc_plus4f;
            ifid_next.valid    = 1'b1;
        end
    end

    // NOTE: the IF/ID register is reset explicitly; Decode must see a defined bubble, not X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.instr    <= NOP_INSTR;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus4 <= '0;
            ifid_q.valid    <= 1'b0;
        end else begin
            ifid_q <= ifid_next;
        end
    end

    // Sticky until reset; the redirect itself still proceeds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             misalign_q <= 1'b0;
        else if (run && bus.PCSrcE && is_misaligned(bus.PCTargetE)) misalign_q <= 1'b1;
    end

    assign bus.InstrD    = ifid_q.instr;
    assign bus.PCD       = ifid_q.pc;
    assign bus.PCPlus4D  = ifid_q.pc_plus4;
    assign bus.ValidD    = ifid_q.valid;
    assign bus.MisalignF = misalign_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (run) begin
            if (bus.stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((bus.flush || bus.PCSrcE) && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.StallCnt = stall_cnt_q;
    assign bus.FlushCnt = flush_cnt_q;
`endif

endmodule
